softmax_in_packer: RTL and testbench

SOFTMAX_IN_PACKER -- requirements
Module: softmax_in_packer

---
 rtl/softmax_in_packer.sv | 156 +++++++++++++++
 tb/tb_softmax_in_packer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/softmax_in_packer.sv
// softmax_in_packer
//   Packs a serial stream of signed Q6.10 scores into LANES-wide vectors for
//   the softmax core. Rows are 16/32/64 elements long, and 4/2/1 rows share
//   one vector. Element k of row slot r lands in lane r*L+k. Lanes that are
//   never written read as the most negative value, so their softmax weight is
//   close to zero.
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_en                  global enable; all state holds while low
//   i_length_mode         row length: 0=16, 1=32, 2/3=64 (sampled per vector)
//   i_in_valid/o_in_ready element handshake (ready mirrors i_en)
//   i_in_data, i_in_last  element value; last ends the current row early
//   i_flush               emit a partially filled vector
//   o_valid               one-cycle pulse; packed vector is valid
//   o_length_mode         mode latched for the emitted vector
//   o_x_flat              packed vector, lane n at [n*DATA_W +: DATA_W]
//   o_row_mask            bit r set if row slot r holds a real element
module softmax_in_packer #(
  parameter int DATA_W = 16,
  parameter int LANES  = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic [1:0]                i_length_mode,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [DATA_W-1:0]         i_in_data,
  input  logic                      i_in_last,
  input  logic                      i_flush,
  output logic                      o_valid,
  output logic [1:0]                o_length_mode,
  output logic [LANES*DATA_W-1:0]   o_x_flat,
  output logic [3:0]                o_row_mask
);

  typedef enum logic [1:0] {
    LEN_16 = 2'd0,
    LEN_32 = 2'd1,
    LEN_64 = 2'd2
  } len_e;

  localparam logic [DATA_W-1:0]       NEG_MAX = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [LANES*DATA_W-1:0] FILL    = {LANES{NEG_MAX}};

  logic [LANES*DATA_W-1:0] asm_q, asm_d;
  logic [1:0]              row_q, row_d;
  logic [5:0]              k_q, k_d;
  logic [3:0]              mask_q, mask_d;
  len_e                    mode_q, mode_eff;
  logic                    vld_q;
  logic                    accept, empty, row_end, emit;
  logic [5:0]              lane, k_last;
  logic [1:0]              row_last;

  assign o_in_ready = i_en & i_rst_n;
  // A pulse scheduled while disabled waits until enable returns.
  assign o_valid    = vld_q & i_en;

  always_comb begin
    accept = i_en & i_in_valid;
    empty  = (row_q == 2'd0) && (k_q == 6'd0);

    // The first element of a vector takes the live mode; later ones reuse
    // the latched one so mid-vector changes are ignored.
    if (empty) begin
      case (i_length_mode)
        2'd0:    mode_eff = LEN_16;
        2'd1:    mode_eff = LEN_32;
        default: mode_eff = LEN_64;
      endcase
    end else begin
      mode_eff = mode_q;
    end

    case (mode_eff)
      LEN_16: begin
        lane     = {row_q, 4'b0000} + k_q;
        k_last   = 6'd15;
        row_last = 2'd3;
      end
      LEN_32: begin
        lane     = {row_q[0], 5'b00000} + k_q;
        k_last   = 6'd31;
        row_last = 2'd1;
      end
      default: begin
        lane     = k_q;
        k_last   = 6'd63;
        row_last = 2'd0;
      end
    endcase

    asm_d   = asm_q;
    row_d   = row_q;
    k_d     = k_q;
    mask_d  = mask_q;
    row_end = 1'b0;
    emit    = 1'b0;

    if (accept) begin
      asm_d[int'(lane)*DATA_W +: DATA_W] = i_in_data;
      mask_d[row_q] = 1'b1;
      row_end = (k_q == k_last) || i_in_last;
      if (row_end) begin
        if (row_q == row_last) begin
          emit = 1'b1;
        end else begin
          row_d = row_q + 2'd1;
          k_d   = 6'd0;
        end
      end else begin
        k_d = k_q + 6'd1;
      end
    end

    // Flush and completion on the same cycle still yield a single emission.
    if (i_en && i_flush && (!empty || accept)) begin
      emit = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      asm_q         <= FILL;
      row_q         <= '0;
      k_q           <= '0;
      mask_q        <= '0;
      mode_q        <= LEN_16;
      vld_q         <= 1'b0;
      o_x_flat      <= '0;
      o_length_mode <= '0;
      o_row_mask    <= '0;
    end else if (i_en) begin
      vld_q <= emit;
      if (accept && empty) begin
        mode_q <= mode_eff;
      end
      if (emit) begin
        o_x_flat      <= asm_d;
        o_length_mode <= mode_eff;
        o_row_mask    <= mask_d;
        asm_q         <= FILL;
        row_q         <= '0;
        k_q           <= '0;
        mask_q        <= '0;
      end else begin
        asm_q  <= asm_d;
        row_q  <= row_d;
        k_q    <= k_d;
        mask_q <= mask_d;
      end
    end
  end

endmodule

// File: tb/tb_softmax_in_packer.sv
module tb_softmax_in_packer;
  localparam int DATA_W = 16;
  localparam int LANES  = 64;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n;
  logic                    i_en;
  logic [1:0]              i_length_mode;
  logic                    i_in_valid;
  logic                    o_in_ready;
  logic [DATA_W-1:0]       i_in_data;
  logic                    i_in_last;
  logic                    i_flush;
  logic                    o_valid;
  logic [1:0]              o_length_mode;
  logic [LANES*DATA_W-1:0] o_x_flat;
  logic [3:0]              o_row_mask;

  always #5 i_clk = ~i_clk;

  softmax_in_packer #(.DATA_W(DATA_W), .LANES(LANES)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (i_en),
    .i_length_mode (i_length_mode),
    .i_in_valid    (i_in_valid),
    .o_in_ready    (o_in_ready),
    .i_in_data     (i_in_data),
    .i_in_last     (i_in_last),
    .i_flush       (i_flush),
    .o_valid       (o_valid),
    .o_length_mode (o_length_mode),
    .o_x_flat      (o_x_flat),
    .o_row_mask    (o_row_mask)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: completed rows kept as lists, the open row as a queue;
  // the vector image is only laid out at emission time.
  logic [15:0] rows [4][64];
  int          rowlen [4];
  int          rows_done;
  logic [15:0] cur [$];
  int          mmode;
  logic [15:0] exp_vec [64];
  int          exp_mode;
  int          exp_mask;
  bit          vpend;

  task automatic model_reset();
    rows_done = 0;
    cur.delete();
    vpend    = 1'b0;
    mmode    = 0;
    exp_mode = 0;
    exp_mask = 0;
    for (int n = 0; n < 64; n++) exp_vec[n] = 16'h0000;
  endtask

  task automatic model_step();
    bit emit;
    int len;
    int nrows;
    emit = 1'b0;
    if (!i_en) return;
    if (i_in_valid) begin
      if (rows_done == 0 && cur.size() == 0)
        mmode = (i_length_mode == 2'd3) ? 2 : int'(i_length_mode);
      len   = 16 << mmode;
      nrows = 64 / len;
      cur.push_back(i_in_data);
      if (cur.size() == len || i_in_last) begin
        for (int i = 0; i < cur.size(); i++) rows[rows_done][i] = cur[i];
        rowlen[rows_done] = cur.size();
        rows_done++;
        cur.delete();
        if (rows_done == nrows) emit = 1'b1;
      end
    end
    if (i_flush && (rows_done > 0 || cur.size() > 0)) emit = 1'b1;
    if (emit) begin
      len = 16 << mmode;
      exp_mask = 0;
      for (int n = 0; n < 64; n++) exp_vec[n] = 16'h8000;
      for (int r = 0; r < rows_done; r++) begin
        for (int i = 0; i < rowlen[r]; i++) exp_vec[r*len + i] = rows[r][i];
        exp_mask |= (1 << r);
      end
      if (cur.size() > 0) begin
        for (int i = 0; i < cur.size(); i++) exp_vec[rows_done*len + i] = cur[i];
        exp_mask |= (1 << rows_done);
      end
      exp_mode  = mmode;
      rows_done = 0;
      cur.delete();
    end
    vpend = emit;
  endtask

  task automatic tick(input bit en, input bit v, input logic [15:0] d,
                      input bit last, input bit fl, input logic [1:0] mode);
    i_en = en; i_in_valid = v; i_in_data = d;
    i_in_last = last; i_flush = fl; i_length_mode = mode;
    if (!i_rst_n) model_reset();
    @(negedge i_clk);
    check("in_ready", 32'(o_in_ready), 32'(en && i_rst_n));
    check("o_valid", 32'(o_valid), 32'(vpend && en));
    if (o_valid) pulses++;
    check("length_mode", 32'(o_length_mode), 32'(exp_mode));
    check("row_mask", 32'(o_row_mask), 32'(exp_mask));
    for (int n = 0; n < 64; n++)
      check($sformatf("lane%0d", n), 32'(o_x_flat[n*16 +: 16]), 32'(exp_vec[n]));
    @(posedge i_clk);
    if (i_rst_n) model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 16'h0, 0, 0, 2'd2);
  endtask

  initial begin
    int p0;
    i_rst_n = 1'b0;
    model_reset();
    repeat (3) tick(1, 1, 16'h1234, 0, 0, 2'd2);
    i_rst_n = 1'b1;
    idle(1);

    // Mode 2: data = lane index.
    for (int i = 0; i < 64; i++) tick(1, 1, 16'(i), 0, 0, 2'd2);
    idle(2);

    // Mode 0: short row 0, then three full rows.
    for (int i = 0; i < 5; i++) tick(1, 1, 16'(16'h0100 + i), i == 4, 0, 2'd0);
    for (int i = 0; i < 48; i++) tick(1, 1, 16'(16'h0200 + i), 0, 0, 2'd0);
    idle(2);

    // Mode 1: partial vector flushed, then a flush with nothing pending.
    for (int i = 0; i < 20; i++) tick(1, 1, 16'(16'h0300 + i), 0, 0, 2'd1);
    tick(1, 0, 16'h0, 0, 1, 2'd1);
    idle(2);
    p0 = pulses;
    tick(1, 0, 16'h0, 0, 1, 2'd1);
    idle(2);
    check("empty_flush_pulses", 32'(pulses - p0), 32'd0);

    // Mode changes mid-vector are ignored.
    p0 = pulses;
    for (int i = 0; i < 128; i++)
      tick(1, 1, 16'($urandom), 0, 0, ((i % 64) < 30) ? 2'd2 : 2'd0);
    idle(2);
    check("mode_change_pulses", 32'(pulses - p0), 32'd2);

    // Enable low mid-vector, then low again right after completion.
    for (int i = 0; i < 30; i++) tick(1, 1, 16'($urandom), 0, 0, 2'd2);
    for (int i = 0; i < 10; i++) tick(0, 1, 16'($urandom), 1, $urandom_range(0, 1), 2'd0);
    for (int i = 0; i < 34; i++) tick(1, 1, 16'($urandom), 0, 0, 2'd2);
    for (int i = 0; i < 3; i++) tick(0, 1, 16'($urandom), 0, 1, 2'd2);
    idle(2);

    // Reset mid-vector discards the pending elements.
    p0 = pulses;
    for (int i = 0; i < 20; i++) tick(1, 1, 16'($urandom), 0, 0, 2'd2);
    i_rst_n = 1'b0;
    tick(1, 1, 16'h5555, 0, 1, 2'd2);
    tick(1, 1, 16'h5555, 0, 1, 2'd2);
    i_rst_n = 1'b1;
    idle(3);
    check("reset_no_pulse", 32'(pulses - p0), 32'd0);
    for (int i = 0; i < 64; i++) tick(1, 1, 16'($urandom), 0, 0, 2'd2);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      tick(($urandom % 8) != 0, ($urandom % 4) != 0, 16'($urandom),
           ($urandom % 16) == 0, ($urandom % 32) == 0, 2'($urandom));
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
